// File: rtl/i2s_buf_loader.sv
// i2s_buf_loader: refills the I2S transmitter's ping-pong sample RAM from a
// valid/ready sample stream. It primes the whole RAM once, then refills
// whichever half the codec reports as consumed. The lower half is refilled
// first when both are pending.
module i2s_buf_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  conf_en,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  evt_lsbf,
  input  logic                  evt_hsbf,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  primed,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  // First address of the upper half, and the last address of each half.
  localparam logic [ADDR_WIDTH-1:0] HALF_BASE = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_LO   = {1'b0, {(ADDR_WIDTH-1){1'b1}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_ALL  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRIME   = 3'd1,
    S_WAIT    = 3'd2,
    S_FILL_LO = 3'd3,
    S_FILL_HI = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    pend_lo_q, pend_lo_d;
  logic                    pend_hi_q, pend_hi_d;
  logic                    evt_lo_q, evt_lo_d;
  logic                    evt_hi_q, evt_hi_d;
  logic                    primed_q, primed_d;
  logic                    underrun_q, underrun_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

  logic xfer;
  logic lo_evt;
  logic hi_evt;
  logic underrun_set;

  // Handshake and event rising edges; events only count once the RAM is primed.
  assign xfer   = s_valid && s_ready;
  assign lo_evt = evt_lsbf && !evt_lo_q && primed_q;
  assign hi_evt = evt_hsbf && !evt_hi_q && primed_q;

  // State register.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dropping conf_en aborts from any state.
  always_comb begin
    state_d = state_q;
    if (!conf_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_PRIME;
        S_PRIME:   if (xfer && ptr_q == LAST_ALL) state_d = S_WAIT;
        S_WAIT: begin
          if (pend_lo_q)      state_d = S_FILL_LO;
          else if (pend_hi_q) state_d = S_FILL_HI;
        end
        S_FILL_LO: if (xfer && ptr_q == LAST_LO)  state_d = S_WAIT;
        S_FILL_HI: if (xfer && ptr_q == LAST_ALL) state_d = S_WAIT;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output decode: ready is purely a function of the registered state.
  always_comb begin
    s_ready = (state_q == S_PRIME) || (state_q == S_FILL_LO) || (state_q == S_FILL_HI);
  end

  // Pointer, pending flags, status flags and the one-cycle-delayed write port.
  always_comb begin
    ptr_d        = ptr_q;
    pend_lo_d    = pend_lo_q;
    pend_hi_d    = pend_hi_q;
    primed_d     = primed_q;
    underrun_set = 1'b0;
    evt_lo_d     = evt_lsbf;
    evt_hi_d     = evt_hsbf;

    if (xfer) ptr_d = ptr_q + 1'b1;

    case (state_q)
      S_IDLE:  ptr_d = '0;
      S_PRIME: if (xfer && ptr_q == LAST_ALL) primed_d = 1'b1;
      S_WAIT: begin
        // Pending flag is consumed as the fill for that half starts.
        if (pend_lo_q) begin
          ptr_d     = '0;
          pend_lo_d = 1'b0;
        end else if (pend_hi_q) begin
          ptr_d     = HALF_BASE;
          pend_hi_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A freed half that was still pending, or is being filled right now,
    // means the codec has outrun us; queue the half for another refill.
    if (lo_evt) begin
      pend_lo_d = 1'b1;
      if (pend_lo_q || state_q == S_FILL_LO) underrun_set = 1'b1;
    end
    if (hi_evt) begin
      pend_hi_d = 1'b1;
      if (pend_hi_q || state_q == S_FILL_HI) underrun_set = 1'b1;
    end

    if (!conf_en) begin
      ptr_d     = '0;
      pend_lo_d = 1'b0;
      pend_hi_d = 1'b0;
      primed_d  = 1'b0;
    end

    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (underrun_set) underrun_d = 1'b1;

    // An accepted sample is always written, even if conf_en drops now.
    wr_en_d    = xfer;
    wr_addr_d  = xfer ? ptr_q  : wr_addr_q;
    data_out_d = xfer ? s_data : data_out_q;
  end

  // Datapath and flag registers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ptr_q      <= '0;
      pend_lo_q  <= 1'b0;
      pend_hi_q  <= 1'b0;
      evt_lo_q   <= 1'b0;
      evt_hi_q   <= 1'b0;
      primed_q   <= 1'b0;
      underrun_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      data_out_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pend_lo_q  <= pend_lo_d;
      pend_hi_q  <= pend_hi_d;
      evt_lo_q   <= evt_lo_d;
      evt_hi_q   <= evt_hi_d;
      primed_q   <= primed_d;
      underrun_q <= underrun_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      data_out_q <= data_out_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign data_out = data_out_q;
  assign primed   = primed_q;
  assign underrun = underrun_q;

endmodule
